// File: rtl/processor_multicycle.sv
// Multi-cycle RV32I-subset core (R-type ALU ops + ADDI) with internal register file.
// Four-state FETCH/DECODE/EXEC/WB loop; instruction fetch uses a req/ack handshake.
module processor_multicycle #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            zero_flag,
    output logic            retire,
    output logic            illegal,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic              legal_q, legal_d;
    logic              req_q, req_d;
    logic              zero_q, zero_d;
    logic              retire_q, retire_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   rf_q [NREGS];
    logic [XLEN-1:0]   rf_d [NREGS];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [RW-1:0]     rs1, rs2, rd;
    logic [XLEN-1:0]   imm;
    logic              dec_legal;
    logic              alt_op;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   alu;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign rd     = ir_q[7 +: RW];
    assign rs1    = ir_q[15 +: RW];
    assign rs2    = ir_q[20 +: RW];
    assign imm    = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    // ADDI's upper immediate bits overlap funct7, so the SUB/SRA select is R-type only.
    assign alt_op = (opcode == OP_REG) && ir_q[30];
    assign shamt  = b_q[SW-1:0];

    always_comb begin
        dec_legal = 1'b0;
        if (opcode == OP_REG) begin
            if (funct7 == 7'b0000000)
                dec_legal = 1'b1;
            else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                dec_legal = 1'b1;
        end else if (opcode == OP_IMM && funct3 == 3'b000) begin
            dec_legal = 1'b1;
        end
    end

    always_comb begin
        alu = '0;
        case (funct3)
            3'b000:  alu = alt_op ? (a_q - b_q) : (a_q + b_q);
            3'b001:  alu = a_q << shamt;
            3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            3'b011:  alu = {{(XLEN-1){1'b0}}, a_q < b_q};
            3'b100:  alu = a_q ^ b_q;
            3'b101:  alu = alt_op ? XLEN'($signed(a_q) >>> shamt) : (a_q >> shamt);
            3'b110:  alu = a_q | b_q;
            default: alu = a_q & b_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        legal_d   = legal_q;
        req_d     = req_q;
        zero_d    = zero_q;
        retire_d  = 1'b0;
        illegal_d = illegal_q;
        rf_d      = rf_q;
        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_q[rs1];
                b_d     = (opcode == OP_IMM) ? imm : rf_q[rs2];
                legal_d = dec_legal;
                if (!dec_legal) illegal_d = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                r_d      = alu;
                if (legal_q) zero_d = (alu == '0);
                retire_d = 1'b1;
                state_d  = WB;
            end
            default: begin
                if (legal_q && rd != '0) rf_d[rd] = r_q;
                pc_d    = pc_q + XLEN'(4);
                // Raise the request now so a zero-wait fetch completes in its first cycle.
                req_d   = 1'b1;
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            legal_q   <= 1'b0;
            req_q     <= 1'b0;
            zero_q    <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            rf_q      <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            legal_q   <= legal_d;
            req_q     <= req_d;
            zero_q    <= zero_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            rf_q      <= rf_d;
        end
    end

    always_comb begin
        dbg_rdata = '0;
        if (int'(dbg_raddr) < NREGS) dbg_rdata = rf_q[dbg_raddr[RW-1:0]];
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign zero_flag = zero_q;
    assign retire    = retire_q;
    assign illegal   = illegal_q;
endmodule
